// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer handling fetch handshake, stall, branch, jump and halt.
// Optional build macro ALIGN_CHECK_EN: forces word-aligned redirect targets and halts on misalignment.
`default_nettype none

module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          TIMEOUT      = 16,
    parameter int          CNT_W        = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] next_pc,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    input  logic        resume,
    output logic        halted,
    output logic        fetch_err,
`ifdef ALIGN_CHECK_EN
    output logic        align_err,
`endif
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   tmo_cnt, tmo_nx;
    logic               err_set, err_clr, count_inc;
    logic [31:0]        redirect_pc;
    logic               redirect_sel;

`ifdef ALIGN_CHECK_EN
    logic               align_set;
    logic               redirect_mis;
`endif

    always_comb begin
        state_nx     = state;
        next_pc      = pc_in;
        tmo_nx       = '0;
        err_set      = 1'b0;
        err_clr      = 1'b0;
        count_inc    = 1'b0;
        redirect_sel = 1'b0;
        redirect_pc  = jump ? jump_target : branch_target;
`ifdef ALIGN_CHECK_EN
        align_set    = 1'b0;
        redirect_mis = |redirect_pc[1:0];
        redirect_pc  = {redirect_pc[31:2], 2'b00};
`endif
        case (state)
            S_BOOT: begin
                next_pc  = RESET_VECTOR;
                state_nx = S_FETCH;
            end
            S_FETCH: begin
                // A late ack on the timeout cycle still counts as success.
                if (imem_ack) begin
                    state_nx = S_ISSUE;
                end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nx = S_HALTED;
                    err_set  = 1'b1;
                end else begin
                    tmo_nx = tmo_cnt + 1'b1;
                end
            end
            S_ISSUE: begin
                if (stall) begin
                    state_nx = S_ISSUE;
                end else if (halt) begin
                    state_nx  = S_HALTED;
                    count_inc = 1'b1;
                end else if (jump || branch_taken) begin
                    redirect_sel = 1'b1;
                    next_pc      = redirect_pc;
                    state_nx     = S_FETCH;
                    count_inc    = 1'b1;
`ifdef ALIGN_CHECK_EN
                    if (redirect_mis) begin
                        state_nx  = S_HALTED;
                        align_set = 1'b1;
                    end
`endif
                end else begin
                    next_pc   = pc_in + 32'd4;
                    state_nx  = S_FETCH;
                    count_inc = 1'b1;
                end
            end
            S_HALTED: begin
                if (resume && !halt) begin
                    state_nx = S_FETCH;
                    err_clr  = 1'b1;
                end
            end
            default: begin
                state_nx = S_BOOT;
                next_pc  = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_BOOT;
            tmo_cnt     <= '0;
            fetch_err   <= 1'b0;
            instr_count <= 32'd0;
        end else begin
            state   <= state_nx;
            tmo_cnt <= tmo_nx;
            if (err_set) begin
                fetch_err <= 1'b1;
            end else if (err_clr) begin
                fetch_err <= 1'b0;
            end
            if (count_inc) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end

`ifdef ALIGN_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            align_err <= 1'b0;
        end else if (align_set) begin
            align_err <= 1'b1;
        end else if (err_clr) begin
            align_err <= 1'b0;
        end
    end
`endif

    assign imem_req    = (state == S_FETCH);
    assign instr_valid = (state == S_ISSUE);
    assign halted      = (state == S_HALTED);

    // redirect_sel only marks the redirect path for readability in waves.
    logic unused_sel;
    assign unused_sel = redirect_sel;

endmodule

`default_nettype wire
